// File: rtl/dut.sv
// Parameterised D register / fixed-latency delay line: STAGES register stages
// between D and Q, synchronous active-high reset to RESET_VAL, no enable.
module dut #(
  parameter int unsigned          WIDTH     = 4,
  parameter int unsigned          STAGES    = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) stage[0] <= RESET_VAL;
    else     stage[0] <= D;
  end

  // One flop per generated stage so the default single-stage build has no
  // out-of-range stage[i-1] term, even in dead code.
  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) stage[g] <= RESET_VAL;
      else     stage[g] <= stage[g-1];
    end
  end

  assign Q = stage[STAGES-1];

endmodule

// File: tb/tb_dut.sv
// Directed bench for dut: default 4-bit/1-stage instance driven from a vector
// table, plus hand sequences for reset glitch, hold and an 8-bit/3-stage build.
module tb_dut;

  logic       clk;
  logic       rst;
  logic [3:0] D;
  logic [3:0] Q;

  logic       rst8;
  logic [7:0] D8;
  logic [7:0] Q8;

  int n_tests = 0;
  int n_fail  = 0;

  dut u_dut (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .Q   (Q)
  );

  dut #(
    .WIDTH     (8),
    .STAGES    (3),
    .RESET_VAL (8'hA5)
  ) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .D   (D8),
    .Q   (Q8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] d;
    logic [3:0] q;   // Q expected at the falling edge after d is driven
  } vec_t;

  vec_t vecs [15];
  logic [7:0] stream8 [11];

  initial begin
    // Each row's q is the value captured at the rising edge just before the
    // row's inputs are driven, i.e. the previous row's d (or reset result).
    vecs[0]  = '{1'b0, 4'h4, 4'h4};
    vecs[1]  = '{1'b0, 4'h1, 4'h4};
    vecs[2]  = '{1'b0, 4'h9, 4'h1};
    vecs[3]  = '{1'b0, 4'h3, 4'h9};
    vecs[4]  = '{1'b0, 4'hD, 4'h3};
    vecs[5]  = '{1'b0, 4'hD, 4'hD};
    vecs[6]  = '{1'b0, 4'h5, 4'hD};
    vecs[7]  = '{1'b0, 4'h2, 4'h5};
    vecs[8]  = '{1'b0, 4'h1, 4'h2};
    vecs[9]  = '{1'b0, 4'hD, 4'h1};
    vecs[10] = '{1'b0, 4'hA, 4'hD};
    vecs[11] = '{1'b1, 4'hF, 4'hA};
    vecs[12] = '{1'b0, 4'h7, 4'h0};
    vecs[13] = '{1'b0, 4'h5, 4'h7};
    vecs[14] = '{1'b0, 4'h5, 4'h5};

    stream8 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                8'hDE, 8'hF0, 8'h11, 8'h22, 8'h33};

    rst  = 1'b0;
    D    = 4'h4;
    rst8 = 1'b1;
    D8   = 8'h00;

    // Power-up capture with no reset
    @(negedge clk);
    check("powerup", {4'h0, Q}, 8'h04);

    // Streaming and synchronous reset
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst;
      D   = vecs[i].d;
      @(negedge clk);
      check($sformatf("vec%0d", i), {4'h0, Q}, {4'h0, vecs[i].q});
    end

    // 1-unit reset glitch inside the low phase must be ignored
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    D = 4'h6;
    #1;
    check("glitch_hold", {4'h0, Q}, 8'h05);
    @(posedge clk);
    #1;
    check("glitch_next", {4'h0, Q}, 8'h06);

    // D bouncing within one low phase; only the settled value is captured
    @(negedge clk);
    D = 4'h3; #1 D = 4'hC; #1 D = 4'h3; #1 D = 4'hC;
    @(posedge clk);
    #1;
    check("bounce_cap", {4'h0, Q}, 8'h0C);
    D = 4'h3;
    @(negedge clk);
    check("bounce_fall", {4'h0, Q}, 8'h0C);
    #4;
    check("bounce_late", {4'h0, Q}, 8'h0C);
    @(posedge clk);
    #1;
    check("bounce_next", {4'h0, Q}, 8'h03);

    // 8-bit, 3-stage instance: reset value then 3-edge latency
    @(negedge clk);
    rst8 = 1'b1;
    D8   = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    check("p_reset", Q8, 8'hA5);
    rst8 = 1'b0;
    D8   = stream8[0];
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("p_stream%0d", k), Q8, (k >= 2) ? stream8[k-2] : 8'hA5);
      D8 = stream8[k+1];
    end

    // Mid-stream reset discards everything in flight
    rst8 = 1'b1;
    D8   = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    check("p_midrst", Q8, 8'hA5);
    rst8 = 1'b0;
    D8   = 8'h77;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("p_after%0d", j), Q8, (j == 2) ? 8'h77 : 8'hA5);
      D8 = 8'h88;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
